sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the board's single-port asynchronous 16-bit SRAM between two requesters: the VGA scan-out fetch port (read-only) and the CPU data port (read/write with byte enables). It sequences every access as a fixed multi-cycle SETUP/ACCESS/DONE transaction that drives the SRAM pins, and returns a one-cycle acknowledge with captured read data. It sits between `top` and the pad ring in the IceZero build, replacing the tied-off CPU data input.

## Interface
- `AW`, 18, SRAM word-address width; the CPU's 14-bit address is zero-extended by the caller.
- `WAIT_CYCLES`, 1, extra cycles in ACCESS; ACCESS lasts `WAIT_CYCLES+1` cycles. Legal range 0..15.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `vga_req` in 1: VGA read request, level.
- `vga_addr` in AW: VGA word address.
- `vga_ack` out 1: one-cycle completion pulse.
- `vga_rdata` out 16: read data.
- `cpu_req` in 1: CPU request, level.
- `cpu_we` in 1: 1 = write.
- `cpu_be` in 2: byte enables; bit0 = low byte.
- `cpu_addr` in AW: CPU word address.
- `cpu_wdata` in 16: write data.
- `cpu_ack` out 1: one-cycle completion pulse.
- `cpu_rdata` out 16: read data.
- `sram_addr` out AW: SRAM address.
- `sram_dq_out` out 16: SRAM write data.
- `sram_dq_oe` out 1: pad output enable.
- `sram_dq_in` in 16: SRAM data from the pads.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` out 1 each: active-low strobes.

## Operation
- Handshake: the requester raises `req` with address, `we`, `be` and `wdata` stable, and holds them until it samples `ack`=1. It must drop `req` (or present a new request) on that same edge. If `req` is still high in IDLE, that is a new request.
- If a requester drops `req` early, the transaction already granted still completes and acks.
- FSM states are IDLE, SETUP, ACCESS and DONE.
- IDLE: arbitrate and register the winner's address, data, `we` and `be`, then go to SETUP. If there is no request, stay in IDLE.
- SETUP (1 cycle): `ce_n`=0 and the address is driven. For writes, `dq_oe`=1 and data is driven. `we_n`=1, `oe_n`=1.
- ACCESS (`WAIT_CYCLES+1` cycles), counted by an internal counter:
  - Write: `we_n`=0, `lb_n`/`ub_n` = ~`be`.
  - Read: `oe_n`=0, `lb_n`=`ub_n`=0.
  - On the edge leaving ACCESS, a read captures `sram_dq_in` into the winner's `rdata`.
- DONE (1 cycle): `we_n`=`oe_n`=1, while `ce_n`, address and write data stay held (hold time). The winner's `ack`=1. Next state is IDLE.
- Default arbitration is fixed priority: VGA wins whenever `vga_req`=1.
- VGA transactions always read with both bytes, regardless of any CPU signals.
- Each port's `rdata` holds its value until that port's next read completes. Writes do not modify `rdata`.

## Timing
- Reset values: `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_lb_n`, `sram_ub_n` = 1; `sram_dq_oe`=0; `sram_addr`=0; `sram_dq_out`=0; both `ack`=0; both `rdata`=0; FSM in IDLE.
- All SRAM pin outputs and acks are registered (no combinational path from inputs).
- Grant edge G (IDLE→SETUP) → ACCESS from G+1 → DONE at G+2+WAIT_CYCLES. The ack is high for the cycle after edge G+2+WAIT_CYCLES.
- With the default WAIT_CYCLES=1:
  - Ack comes 3 cycles after the grant edge.
  - A transaction occupies 5 cycles including IDLE.
  - Back-to-back throughput is one access per 5 cycles.
- Address and write data change only on the grant edge. `we_n` never falls on the same edge the address changes.
- Reset mid-transaction takes effect asynchronously and immediately:
  - All strobes go inactive and `dq_oe`=0.
  - No ack is issued and the transaction is dropped.
  - A requester still holding `req` is re-served from IDLE after release.
- `sram_dq_in` is sampled directly; the SRAM access time must fit in `WAIT_CYCLES+1` clock periods.

## Configuration
- `SRAM_ARB_RR_EN` defined:
  - Arbitration is round-robin. When both requests are high in IDLE, the grant goes to the port that did not win the previous grant.
  - A single requester is always granted.
  - The last-winner flag resets to CPU, so VGA wins the first tie.
- Not defined: fixed VGA priority as above; the last-winner flag is not implemented.

## Test plan
- Reset with both requests high → all strobes 1, `dq_oe`=0, acks 0, `rdata`=0. After release, VGA is granted first.
- CPU write: addr 0x00123, data 0xBEEF, be=11, WAIT_CYCLES=1 → `we_n` low for exactly 2 cycles with `sram_addr`=0x00123 and `dq_out`=0xBEEF; `dq_oe` high from SETUP through DONE; `cpu_ack` 3 cycles after the grant edge.
- VGA read of 0x3FFFF with the SRAM model returning 0x1234 → `oe_n` low 2 cycles, `we_n` never low; `vga_ack` with `vga_rdata`=0x1234; `cpu_rdata` unchanged.
- CPU byte write, be=01, data 0xAA55 → during ACCESS `lb_n`=0, `ub_n`=1; the model's upper byte is unchanged.
- Both requests high continuously for 4 transactions:
  - Without the macro: grants are VGA, VGA, VGA, VGA.
  - With `SRAM_ARB_RR_EN`: grants are VGA, CPU, VGA, CPU.
- Reset asserted in the first ACCESS cycle of a CPU write → `we_n`=1, `ce_n`=1, `dq_oe`=0 immediately, no `cpu_ack`. After release, with `req` held, the full write is repeated and acked.

Source files
------------

// File: rtl/sram_arbiter_if.sv
// Requester handshakes (VGA read port, CPU read/write port) and SRAM pad signals
// shared between sram_arbiter (slave side) and the requesters/pad ring (master side).
interface sram_arbiter_if #(
  parameter int AW = 18
);
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic          vga_ack;
  logic [15:0]   vga_rdata;

  logic          cpu_req;
  logic          cpu_we;
  logic [1:0]    cpu_be;
  logic [AW-1:0] cpu_addr;
  logic [15:0]   cpu_wdata;
  logic          cpu_ack;
  logic [15:0]   cpu_rdata;

  logic [AW-1:0] sram_addr;
  logic [15:0]   sram_dq_out;
  logic          sram_dq_oe;
  logic [15:0]   sram_dq_in;
  logic          sram_ce_n;
  logic          sram_oe_n;
  logic          sram_we_n;
  logic          sram_lb_n;
  logic          sram_ub_n;

  modport slave (
    input  vga_req, vga_addr,
    input  cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    input  sram_dq_in,
    output vga_ack, vga_rdata, cpu_ack, cpu_rdata,
    output sram_addr, sram_dq_out, sram_dq_oe,
    output sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );

  modport master (
    output vga_req, vga_addr,
    output cpu_req, cpu_we, cpu_be, cpu_addr, cpu_wdata,
    output sram_dq_in,
    input  vga_ack, vga_rdata, cpu_ack, cpu_rdata,
    input  sram_addr, sram_dq_out, sram_dq_oe,
    input  sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port async SRAM sequencer (IDLE/SETUP/ACCESS/DONE); SRAM_ARB_RR_EN selects round-robin over fixed VGA priority.
// Ack is registered, WAIT_CYCLES+2 cycles after the grant edge; requesters hold req until ack, no queuing.
module sram_arbiter #(
  parameter int AW          = 18,
  parameter int WAIT_CYCLES = 1
) (
  input  logic          clk,
  input  logic          reset,
  sram_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          win_vga_q, win_vga_d;
  logic          we_q, we_d;
  logic [1:0]    be_q, be_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   dq_out_q, dq_out_d;
  logic          dq_oe_q, dq_oe_d;
  logic          ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic          lb_n_q, lb_n_d, ub_n_q, ub_n_d;
  logic          vga_ack_q, vga_ack_d, cpu_ack_q, cpu_ack_d;
  logic [15:0]   vga_rdata_q, vga_rdata_d, cpu_rdata_q, cpu_rdata_d;
  logic          grant_vga;

`ifdef SRAM_ARB_RR_EN
  logic last_vga_q, last_vga_d;

  // On a tie the port that lost the previous grant wins; flag resets to CPU so VGA wins first.
  always_comb grant_vga = bus.vga_req & (~bus.cpu_req | ~last_vga_q);

  always_comb begin
    last_vga_d = last_vga_q;
    if (state_q == IDLE && (bus.vga_req || bus.cpu_req)) last_vga_d = grant_vga;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_vga_q <= 1'b0;
    else       last_vga_q <= last_vga_d;
  end
`else
  always_comb grant_vga = bus.vga_req;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    win_vga_d   = win_vga_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    dq_out_d    = dq_out_q;
    dq_oe_d     = dq_oe_q;
    ce_n_d      = ce_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    lb_n_d      = lb_n_q;
    ub_n_d      = ub_n_q;
    vga_ack_d   = 1'b0;
    cpu_ack_d   = 1'b0;
    vga_rdata_d = vga_rdata_q;
    cpu_rdata_d = cpu_rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.vga_req || bus.cpu_req) begin
          state_d   = SETUP;
          win_vga_d = grant_vga;
          ce_n_d    = 1'b0;
          oe_n_d    = 1'b1;
          we_n_d    = 1'b1;
          if (grant_vga) begin
            addr_d  = bus.vga_addr;
            we_d    = 1'b0;
            be_d    = 2'b11;
            dq_oe_d = 1'b0;
          end else begin
            addr_d  = bus.cpu_addr;
            we_d    = bus.cpu_we;
            be_d    = bus.cpu_be;
            dq_oe_d = bus.cpu_we;
            if (bus.cpu_we) dq_out_d = bus.cpu_wdata;
          end
        end
      end
      SETUP: begin
        state_d = ACCESS;
        cnt_d   = 4'd0;
        we_n_d  = ~we_q;
        oe_n_d  = we_q;
        lb_n_d  = we_q ? ~be_q[0] : 1'b0;
        ub_n_d  = we_q ? ~be_q[1] : 1'b0;
      end
      ACCESS: begin
        if (cnt_q == 4'(WAIT_CYCLES)) begin
          state_d = DONE;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          lb_n_d  = 1'b1;
          ub_n_d  = 1'b1;
          if (win_vga_q) begin
            vga_ack_d = 1'b1;
            if (!we_q) vga_rdata_d = bus.sram_dq_in;
          end else begin
            cpu_ack_d = 1'b1;
            if (!we_q) cpu_rdata_d = bus.sram_dq_in;
          end
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      DONE: begin
        // ce_n, address and data were held through DONE for SRAM hold time.
        state_d = IDLE;
        ce_n_d  = 1'b1;
        dq_oe_d = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      win_vga_q   <= 1'b0;
      we_q        <= 1'b0;
      be_q        <= 2'b00;
      addr_q      <= '0;
      dq_out_q    <= 16'h0000;
      dq_oe_q     <= 1'b0;
      ce_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      lb_n_q      <= 1'b1;
      ub_n_q      <= 1'b1;
      vga_ack_q   <= 1'b0;
      cpu_ack_q   <= 1'b0;
      vga_rdata_q <= 16'h0000;
      cpu_rdata_q <= 16'h0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      win_vga_q   <= win_vga_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      dq_out_q    <= dq_out_d;
      dq_oe_q     <= dq_oe_d;
      ce_n_q      <= ce_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      lb_n_q      <= lb_n_d;
      ub_n_q      <= ub_n_d;
      vga_ack_q   <= vga_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      vga_rdata_q <= vga_rdata_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

  assign bus.sram_addr   = addr_q;
  assign bus.sram_dq_out = dq_out_q;
  assign bus.sram_dq_oe  = dq_oe_q;
  assign bus.sram_ce_n   = ce_n_q;
  assign bus.sram_oe_n   = oe_n_q;
  assign bus.sram_we_n   = we_n_q;
  assign bus.sram_lb_n   = lb_n_q;
  assign bus.sram_ub_n   = ub_n_q;
  assign bus.vga_ack     = vga_ack_q;
  assign bus.cpu_ack     = cpu_ack_q;
  assign bus.vga_rdata   = vga_rdata_q;
  assign bus.cpu_rdata   = cpu_rdata_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: behavioural async SRAM model, transaction table, arbitration and reset sequences.
module tb_sram_arbiter;
  localparam int AW = 18;
  localparam int W  = 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sram_arbiter_if #(.AW(AW)) bus ();
  sram_arbiter #(.AW(AW), .WAIT_CYCLES(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  logic [15:0] mem [0:(1<<AW)-1];
  int checks = 0;
  int errors = 0;
  int tag    = 0;
  logic [15:0] exp_vga_rd = 16'h0000;
  logic [15:0] exp_cpu_rd = 16'h0000;

  assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr] : 16'h0000;

  always @(posedge clk) begin
    if (!bus.sram_ce_n && !bus.sram_we_n) begin
      if (!bus.sram_lb_n) mem[bus.sram_addr][7:0]  = bus.sram_dq_out[7:0];
      if (!bus.sram_ub_n) mem[bus.sram_addr][15:8] = bus.sram_dq_out[15:8];
    end
  end

  typedef struct {
    logic          is_vga;
    logic          we;
    logic [1:0]    be;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   exp_rdata;
    logic          exp_lb_n;
    logic          exp_ub_n;
    logic [15:0]   exp_mem;
  } txn_t;

  function automatic txn_t mk(input logic v, input logic we, input logic [1:0] be,
                              input logic [AW-1:0] a, input logic [15:0] wd, input logic [15:0] rd,
                              input logic lbn, input logic ubn, input logic [15:0] m);
    txn_t t;
    t.is_vga = v; t.we = we; t.be = be; t.addr = a; t.wdata = wd;
    t.exp_rdata = rd; t.exp_lb_n = lbn; t.exp_ub_n = ubn; t.exp_mem = m;
    return t;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (step %0d): got 0x%0h expected 0x%0h", name, tag, act, exp);
    end
  endtask

  // Called at a negedge with the arbiter idle; the next posedge is the grant edge.
  task automatic run_txn(input txn_t t);
    int   k, ack_k, we_lo, oe_lo, oe_cnt;
    logic addr_bad, dq_bad, lb_bad, ub_bad, other_ack;
    k = -1; ack_k = -1; we_lo = 0; oe_lo = 0; oe_cnt = 0;
    addr_bad = 0; dq_bad = 0; lb_bad = 0; ub_bad = 0; other_ack = 0;
    if (t.is_vga) begin
      bus.vga_req = 1'b1; bus.vga_addr = t.addr;
      bus.cpu_req = 1'b0; bus.cpu_we = 1'b1; bus.cpu_be = 2'b01;
      bus.cpu_addr = ~t.addr; bus.cpu_wdata = 16'hFFFF;
    end else begin
      bus.vga_req = 1'b0; bus.vga_addr = ~t.addr;
      bus.cpu_req = 1'b1; bus.cpu_we = t.we; bus.cpu_be = t.be;
      bus.cpu_addr = t.addr; bus.cpu_wdata = t.wdata;
    end
    while (ack_k < 0 && k < 40) begin
      @(posedge clk); #1; k++;
      if (!bus.sram_we_n) begin
        we_lo++;
        if (bus.sram_dq_out !== t.wdata) dq_bad = 1'b1;
      end
      if (!bus.sram_oe_n) oe_lo++;
      if (bus.sram_dq_oe) oe_cnt++;
      if (!bus.sram_we_n || !bus.sram_oe_n) begin
        if (bus.sram_lb_n !== t.exp_lb_n) lb_bad = 1'b1;
        if (bus.sram_ub_n !== t.exp_ub_n) ub_bad = 1'b1;
      end
      if (!bus.sram_ce_n && bus.sram_addr !== t.addr) addr_bad = 1'b1;
      if (t.is_vga ? bus.cpu_ack : bus.vga_ack) other_ack = 1'b1;
      if (t.is_vga ? bus.vga_ack : bus.cpu_ack) ack_k = k;
    end
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b0;
    check("ack_latency", ack_k, W + 2);
    check("we_n_low_cycles", we_lo, (!t.is_vga && t.we) ? W + 1 : 0);
    check("oe_n_low_cycles", oe_lo, (t.is_vga || !t.we) ? W + 1 : 0);
    check("dq_oe_cycles", oe_cnt, (!t.is_vga && t.we) ? W + 3 : 0);
    check("addr_stable", addr_bad, 0);
    check("dq_out_stable", dq_bad, 0);
    check("lb_n_access", lb_bad, 0);
    check("ub_n_access", ub_bad, 0);
    check("other_ack", other_ack, 0);
    if (t.is_vga) exp_vga_rd = t.exp_rdata;
    else if (!t.we) exp_cpu_rd = t.exp_rdata;
    check("vga_rdata", bus.vga_rdata, exp_vga_rd);
    check("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
    check("sram_contents", mem[t.addr], t.exp_mem);
    @(posedge clk); #1;
    check("ack_pulse", {bus.vga_ack, bus.cpu_ack}, 0);
    check("idle_ce_n", bus.sram_ce_n, 1);
    @(negedge clk);
  endtask

  txn_t tbl [7];
  logic [3:0] order;
  logic [3:0] exp_order;
  int   n_ack, cyc;
  logic saw_ack;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 16'h0000;
    mem[18'h3FFFF] = 16'h1234;

    //        vga  we    be     addr       wdata     rdata     lb_n  ub_n  mem after
    tbl[0] = mk(0, 1, 2'b11, 18'h00123, 16'hBEEF, 16'h0000, 0, 0, 16'hBEEF);
    tbl[1] = mk(1, 0, 2'b11, 18'h3FFFF, 16'h0000, 16'h1234, 0, 0, 16'h1234);
    tbl[2] = mk(0, 1, 2'b01, 18'h00123, 16'hAA55, 16'h0000, 0, 1, 16'hBE55);
    tbl[3] = mk(0, 0, 2'b11, 18'h00123, 16'h0000, 16'hBE55, 0, 0, 16'hBE55);
    tbl[4] = mk(0, 1, 2'b10, 18'h00200, 16'h1234, 16'h0000, 1, 0, 16'h1200);
    tbl[5] = mk(0, 0, 2'b01, 18'h00200, 16'h0000, 16'h1200, 0, 0, 16'h1200);
    tbl[6] = mk(1, 0, 2'b11, 18'h00123, 16'h0000, 16'hBE55, 0, 0, 16'hBE55);

    // Reset held with both requests pending.
    reset = 1'b1;
    bus.vga_req = 1'b1; bus.vga_addr = 18'h00010;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_be = 2'b11;
    bus.cpu_addr = 18'h00020; bus.cpu_wdata = 16'h0000;
    repeat (3) @(posedge clk);
    #1;
    check("rst_strobes", {bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_lb_n, bus.sram_ub_n}, 5'b11111);
    check("rst_dq_oe", bus.sram_dq_oe, 0);
    check("rst_acks", {bus.vga_ack, bus.cpu_ack}, 0);
    check("rst_vga_rdata", bus.vga_rdata, 0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_addr", bus.sram_addr, 0);
    check("rst_dq_out", bus.sram_dq_out, 0);

    // Both requests held for four transactions.
    @(negedge clk);
    reset = 1'b0;
    tag = 100;
    order = 4'b0000; n_ack = 0; cyc = 0;
    while (n_ack < 4 && cyc < 60) begin
      @(posedge clk); #1; cyc++;
      if (bus.vga_ack || bus.cpu_ack) begin
        if (n_ack == 0) check("first_grant_vga", bus.vga_ack, 1);
        order = {order[2:0], bus.vga_ack};
        n_ack++;
      end
    end
    bus.vga_req = 1'b0;
    bus.cpu_req = 1'b0;
`ifdef SRAM_ARB_RR_EN
    exp_order = 4'b1010;
`else
    exp_order = 4'b1111;
`endif
    check("ack_count", n_ack, 4);
    check("grant_order", order, exp_order);
    check("b2b_cycles", cyc, 4 * (W + 4) - 1);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      tag = i;
      run_txn(tbl[i]);
    end

    // Reset in the first ACCESS cycle of a CPU write.
    tag = 200;
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_be = 2'b11;
    bus.cpu_addr = 18'h00300; bus.cpu_wdata = 16'h5A5A;
    @(posedge clk);
    @(posedge clk); #1;
    check("pre_reset_we_n", bus.sram_we_n, 0);
    #1 reset = 1'b1;
    #1;
    check("mid_rst_we_n", bus.sram_we_n, 1);
    check("mid_rst_ce_n", bus.sram_ce_n, 1);
    check("mid_rst_dq_oe", bus.sram_dq_oe, 0);
    check("mid_rst_lb_ub", {bus.sram_lb_n, bus.sram_ub_n}, 2'b11);
    saw_ack = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      if (bus.cpu_ack || bus.vga_ack) saw_ack = 1'b1;
    end
    check("mid_rst_no_ack", saw_ack, 0);
    exp_vga_rd = 16'h0000;
    exp_cpu_rd = 16'h0000;
    check("mid_rst_rdata", {bus.vga_rdata, bus.cpu_rdata}, 0);
    @(negedge clk);
    reset = 1'b0;
    tag = 201;
    run_txn(mk(0, 1, 2'b11, 18'h00300, 16'h5A5A, 16'h0000, 0, 0, 16'h5A5A));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
